cb_residual_mapper: RTL and testbench

CB_RESIDUAL_MAPPER -- requirements
Module: cb_residual_mapper

---
 rtl/cb_residual_mapper_pkg.sv | 28 ++
 rtl/idx_hist_delay.sv | 26 ++
 rtl/cb_residual_mapper.sv | 144 ++++++++++++++
 tb/tb_cb_residual_mapper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_residual_mapper_pkg.sv
// Shared definitions for the codebook residual mapper: FSM encoding, codebook
// limit table and the escape residual pattern.
package cb_residual_mapper_pkg;

  localparam int NUM_CB_DEF = 12;
  localparam int LIMIT_W    = 4;
  localparam logic [31:0] ESC_RESIDUAL = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Largest delta representable in-range for each codebook; unknown indices map to 0.
  function automatic logic [LIMIT_W-1:0] cb_limit(input int unsigned idx);
    case (idx)
      0:             return 4'd12;
      1:             return 4'd10;
      2:             return 4'd8;
      3, 4:          return 4'd6;
      5, 6, 7:       return 4'd4;
      8, 9, 10, 11:  return 4'd2;
      default:       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/idx_hist_delay.sv
// Enable-gated shift register: q_o is the value shifted in DEPTH enables ago.
module idx_hist_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cb_residual_mapper.sv
// Maps prediction deltas onto a per-codeword codebook: residual or escape,
// with one registered output stage and an index history tap.
module cb_residual_mapper
  import cb_residual_mapper_pkg::*;
#(
  parameter int DELTA_W    = 17,
  parameter int IDX_W      = 4,
  parameter int NUM_CB     = NUM_CB_DEF,
  parameter int RES_W      = 4,
  parameter int HIST_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [IDX_W-1:0]   s_index_i,
  input  logic [DELTA_W-1:0] s_delta_i,
  input  logic               s_last_i,
  input  logic               cw_done_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [IDX_W-1:0]   m_index_o,
  output logic [RES_W-1:0]   m_residual_o,
  output logic               m_escape_o,
  output logic               m_bypass_o,
  output logic [DELTA_W-1:0] m_delta_o,
  output logic [RES_W-1:0]   m_delta_max_o,
  output logic               m_last_o,
  output logic [IDX_W-1:0]   idx_hist_o,
  output logic               busy_o
);

  localparam logic [IDX_W:0] NUM_CB_L = NUM_CB[IDX_W:0];

  function automatic logic over_limit(input logic [DELTA_W-1:0] d,
                                      input logic [LIMIT_W-1:0] lim);
    return d > DELTA_W'(lim);
  endfunction

  function automatic logic [RES_W-1:0] map_residual(input logic [DELTA_W-1:0] d,
                                                    input logic [LIMIT_W-1:0] lim);
    return over_limit(d, lim) ? ESC_RESIDUAL[RES_W-1:0] : d[RES_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q;
  logic               accept;
  logic               bypass_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [IDX_W-1:0]   hist_d_p0;
  logic [LIMIT_W-1:0] lim_p0;

  logic               vld_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [RES_W-1:0]   res_p1;
  logic               esc_p1;
  logic               byp_p1;
  logic [DELTA_W-1:0] delta_p1;
  logic [RES_W-1:0]   dmax_p1;
  logic               last_p1;

  // Stage p0: handshake and codebook selection
  assign s_ready_o = (!vld_p1 || m_ready_i) && (state_q != ST_DRAIN);
  assign accept    = s_valid_i && s_ready_o;
  assign bypass_p0 = (state_q == ST_IDLE) && ({1'b0, s_index_i} >= NUM_CB_L);
  assign idx_p0    = (state_q == ST_ACTIVE) ? cur_idx_q : s_index_i;
  assign lim_p0    = bypass_p0 ? '0 : cb_limit(32'(idx_p0));
  assign hist_d_p0 = bypass_p0 ? '1 : idx_p0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= '1;
    end else begin
      state_q <= state_d;
      if (accept && state_q == ST_IDLE && !bypass_p0) cur_idx_q <= s_index_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && s_last_i)        state_d = ST_DRAIN;
        else if (accept && !bypass_p0) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (accept && s_last_i) state_d = ST_DRAIN;
        else if (cw_done_i)     state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!vld_p1 || m_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: output register, held while the consumer stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      res_p1   <= '0;
      esc_p1   <= 1'b0;
      byp_p1   <= 1'b0;
      delta_p1 <= '0;
      dmax_p1  <= '0;
      last_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      idx_p1   <= idx_p0;
      res_p1   <= bypass_p0 ? '0 : map_residual(s_delta_i, lim_p0);
      esc_p1   <= !bypass_p0 && over_limit(s_delta_i, lim_p0);
      byp_p1   <= bypass_p0;
      delta_p1 <= s_delta_i;
      dmax_p1  <= RES_W'(lim_p0);
      last_p1  <= s_last_i;
    end else if (m_ready_i) begin
      vld_p1   <= 1'b0;
    end
  end

  idx_hist_delay #(
    .WIDTH (IDX_W),
    .DEPTH (HIST_DEPTH)
  ) u_idx_hist (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (accept),
    .d_i   (hist_d_p0),
    .q_o   (idx_hist_o)
  );

  assign m_valid_o     = vld_p1;
  assign m_index_o     = idx_p1;
  assign m_residual_o  = res_p1;
  assign m_escape_o    = esc_p1;
  assign m_bypass_o    = byp_p1;
  assign m_delta_o     = delta_p1;
  assign m_delta_max_o = dmax_p1;
  assign m_last_o      = last_p1;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cb_residual_mapper.sv
// Directed bench for cb_residual_mapper with a beat-level reference model.
module tb_cb_residual_mapper;

  localparam int DELTA_W = 17;
  localparam int IDX_W = 4;
  localparam int NUM_CB = 12;
  localparam int RES_W = 4;
  localparam int HIST_DEPTH = 2;

  typedef struct {
    int idx; int res; int esc; int byp; int delta; int dmax; int last;
  } beat_t;

  logic clk_i = 0, rst_i = 1;
  logic s_valid_i = 0, s_last_i = 0, cw_done_i = 0, m_ready_i = 1;
  logic [IDX_W-1:0] s_index_i = '0;
  logic [DELTA_W-1:0] s_delta_i = '0;
  logic s_ready_o, m_valid_o, m_escape_o, m_bypass_o, m_last_o, busy_o;
  logic [IDX_W-1:0] m_index_o, idx_hist_o;
  logic [RES_W-1:0] m_residual_o, m_delta_max_o;
  logic [DELTA_W-1:0] m_delta_o;

  int tests = 0, fails = 0;
  int lim_tab [12] = '{12, 10, 8, 6, 6, 4, 4, 4, 2, 2, 2, 2};
  beat_t exp_q[$];
  beat_t rx[$];
  int hist_q[$];
  bit open_cb = 0;
  int cur_cb = 0;

  cb_residual_mapper #(
    .DELTA_W(DELTA_W), .IDX_W(IDX_W), .NUM_CB(NUM_CB), .RES_W(RES_W), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_index_i(s_index_i), .s_delta_i(s_delta_i), .s_last_i(s_last_i), .cw_done_i(cw_done_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_index_o(m_index_o),
    .m_residual_o(m_residual_o), .m_escape_o(m_escape_o), .m_bypass_o(m_bypass_o),
    .m_delta_o(m_delta_o), .m_delta_max_o(m_delta_max_o), .m_last_o(m_last_o),
    .idx_hist_o(idx_hist_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: codebook is opened by an in-range index while none is open,
  // closed by cw_done while open, or by a last beat.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q.delete(); hist_q.delete(); open_cb = 0; cur_cb = 0;
    end else begin
      bit was_open;
      beat_t e;
      int lim;
      was_open = open_cb;
      if (m_valid_o && m_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (s_valid_i && s_ready_o) begin
        if (open_cb) begin
          e.idx = cur_cb; e.byp = 0;
        end else if (int'(s_index_i) < NUM_CB) begin
          cur_cb = int'(s_index_i); open_cb = 1; e.idx = cur_cb; e.byp = 0;
        end else begin
          e.idx = int'(s_index_i); e.byp = 1;
        end
        lim = e.byp ? 0 : lim_tab[e.idx];
        e.dmax = lim;
        e.delta = int'(s_delta_i);
        e.last = int'(s_last_i);
        e.esc = (!e.byp && e.delta > lim) ? 1 : 0;
        e.res = e.byp ? 0 : (e.esc ? 15 : e.delta % 16);
        exp_q.push_back(e);
        hist_q.push_back(e.byp ? 15 : e.idx);
        if (s_last_i) open_cb = 0;
      end
      if (cw_done_i && was_open) open_cb = 0;
    end
  end

  // Compare on the falling edge, every cycle outside reset
  always @(negedge clk_i) begin
    if (!rst_i) begin
      int h;
      beat_t a;
      h = (hist_q.size() >= HIST_DEPTH) ? hist_q[hist_q.size() - HIST_DEPTH] : 0;
      chk("idx_hist", int'(idx_hist_o), h);
      if (m_valid_o) begin
        a.idx = int'(m_index_o); a.res = int'(m_residual_o); a.esc = int'(m_escape_o);
        a.byp = int'(m_bypass_o); a.delta = int'(m_delta_o); a.dmax = int'(m_delta_max_o);
        a.last = int'(m_last_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("beat_idx", a.idx, exp_q[0].idx);
          chk("beat_res", a.res, exp_q[0].res);
          chk("beat_esc", a.esc, exp_q[0].esc);
          chk("beat_byp", a.byp, exp_q[0].byp);
          chk("beat_delta", a.delta, exp_q[0].delta);
          chk("beat_dmax", a.dmax, exp_q[0].dmax);
          chk("beat_last", a.last, exp_q[0].last);
        end
        if (m_ready_i) rx.push_back(a);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send(input int idx, input int delta, input bit last, input bit done);
    int n;
    n = 0;
    s_valid_i = 1; s_index_i = IDX_W'(idx); s_delta_i = DELTA_W'(delta);
    s_last_i = last; cw_done_i = done;
    while (1) begin
      @(negedge clk_i);
      if (s_ready_o) break;
      n++;
      if (n > 50) begin chk("send_timeout", 1, 0); break; end
    end
    @(posedge clk_i); #1;
    s_valid_i = 0; s_last_i = 0; cw_done_i = 0;
  endtask

  task automatic done_pulse();
    cw_done_i = 1; step(1); cw_done_i = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_m_valid", int'(m_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_hist", int'(idx_hist_o), 0);
    chk("rst_residual", int'(m_residual_o), 0);
    chk("rst_s_ready", int'(s_ready_o), 1);
    @(posedge clk_i); #1;
    rst_i = 0;
    step(1);

    // Codebook held across beats, escape on exceeding limit
    send(3, 5, 0, 0);
    send(7, 9, 0, 0);
    step(1);
    chk("hist_after_two", int'(idx_hist_o), 3);
    done_pulse();

    // Bypass in IDLE, then a fresh codebook at its exact limit
    send(15, 4, 0, 0);
    @(negedge clk_i); chk("bypass_busy", int'(busy_o), 0);
    step(1);
    send(0, 12, 0, 0);
    done_pulse();

    // cw_done with a beat in the same cycle still uses the open codebook
    send(8, 1, 0, 0);
    send(1, 3, 0, 1);
    send(1, 10, 0, 0);
    done_pulse();

    // Consumer stall with more beats offered
    m_ready_i = 0;
    send(2, 1, 0, 0);
    s_valid_i = 1; s_index_i = 4'd9; s_delta_i = 17'd6;
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_s_ready", int'(s_ready_o), 0);
      chk("stall_m_valid", int'(m_valid_o), 1);
    end
    @(posedge clk_i); #1;
    m_ready_i = 1;
    send(9, 6, 0, 0);
    send(9, 7, 0, 0);
    done_pulse();

    // Last beat under stall: DRAIN until the handshake
    m_ready_i = 0;
    send(5, 3, 1, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("drain_s_ready", int'(s_ready_o), 0);
      chk("drain_busy", int'(busy_o), 1);
    end
    @(posedge clk_i); #1;
    m_ready_i = 1;
    @(negedge clk_i);
    chk("drain_pre_hs_busy", int'(busy_o), 1);
    @(negedge clk_i);
    chk("drain_post_busy", int'(busy_o), 0);
    chk("drain_post_s_ready", int'(s_ready_o), 1);
    chk("drain_post_m_valid", int'(m_valid_o), 0);
    @(posedge clk_i); #1;

    // Wide delta must not alias into range; reset mid-stall drops the beat
    send(8, 65538, 0, 0);
    step(1);
    m_ready_i = 0;
    send(8, 1, 0, 0);
    step(2);
    rst_i = 1;
    @(negedge clk_i);
    chk("rst_stall_m_valid", int'(m_valid_o), 0);
    chk("rst_stall_busy", int'(busy_o), 0);
    step(2);
    rst_i = 0; m_ready_i = 1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_no_beat", int'(m_valid_o), 0);
    end
    @(posedge clk_i); #1;
    send(4, 4, 0, 0);
    step(3);

    // Literal pins on the delivered beats
    chk("rx_count", rx.size(), 13);
    chk("exp_q_empty", exp_q.size(), 0);
    if (rx.size() == 13) begin
      chk("b0_idx", rx[0].idx, 3);    chk("b0_res", rx[0].res, 5);    chk("b0_esc", rx[0].esc, 0);
      chk("b1_idx", rx[1].idx, 3);    chk("b1_res", rx[1].res, 15);   chk("b1_esc", rx[1].esc, 1);
      chk("b2_byp", rx[2].byp, 1);    chk("b2_res", rx[2].res, 0);    chk("b2_dmax", rx[2].dmax, 0);
      chk("b3_idx", rx[3].idx, 0);    chk("b3_res", rx[3].res, 12);   chk("b3_esc", rx[3].esc, 0);
      chk("b4_idx", rx[4].idx, 8);    chk("b5_idx", rx[5].idx, 8);    chk("b6_idx", rx[6].idx, 1);
      chk("b6_res", rx[6].res, 10);   chk("b7_res", rx[7].res, 1);    chk("b8_res", rx[8].res, 6);
      chk("b9_res", rx[9].res, 7);    chk("b9_idx", rx[9].idx, 2);    chk("b10_last", rx[10].last, 1);
      chk("b11_esc", rx[11].esc, 1);  chk("b11_res", rx[11].res, 15); chk("b12_idx", rx[12].idx, 4);
      chk("b12_res", rx[12].res, 4);  chk("b12_dmax", rx[12].dmax, 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
